rv32_lsu_stage: RTL and testbench

RV32_LSU_STAGE -- requirements
Module: rv32_lsu_stage

---
 rtl/rv32_lsu_stage.sv | 169 ++++++++++++++++
 tb/tb_rv32_lsu_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_lsu_stage.sv
// RV32 load/store stage: a circular store buffer drains to the data bus ahead of loads.
// Optional feature macro: RV32_LSU_MISALIGN_TRAP_EN (trap misaligned accesses instead of masking the address).
package rv32_lsu_pkg;
    typedef enum logic [3:0] {
        MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
    } mem_op_t;

    // Only the interrupt-enable bit of mstatus reaches this stage.
    typedef struct packed {
        logic mie;
    } mstatus_t;

    typedef struct packed {
        logic    is_bubble;
        logic    is_mret;
        logic    csr_wb;
        logic    reg_wb;
        mem_op_t mem_op;
    } control_t;

    typedef struct packed {
        logic [31:0]      instr;
        logic [31:0]      pc;
        control_t         control;
        logic [1:0][31:0] data_result;
    } exec_mem_buffer_t;

    typedef exec_mem_buffer_t mem_wb_buffer_t;

    typedef struct packed {
        logic [31:0] from;
        logic        is_mret;
        logic        do_interrupt;
    } interrupt_request_t;

    typedef struct packed {
        logic [31:0] addr;
        mem_op_t     op;
        logic [31:0] data;
    } memory_request_t;

    typedef struct packed {
        logic [11:0] id;
        logic [31:0] value;
        logic        write;
    } csr_write_request_t;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;
    localparam control_t BUBBLE_CONTROL = '{is_bubble: 1'b1, is_mret: 1'b0, csr_wb: 1'b0,
                                            reg_wb: 1'b0, mem_op: MEM_NOP};
endpackage

module rv32_lsu_stage
    import rv32_lsu_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int SB_CNT_W = $clog2(SB_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  mstatus_t                mstatus,
    input  logic                    mtip,
    input  exec_mem_buffer_t        exec_mem_buff,
    output mem_wb_buffer_t          mem_wb_buff,
    output logic                    stall,
    output interrupt_request_t      interrupt_request,
    output memory_request_t         data_request,
    input  logic                    request_done,
    output csr_write_request_t      csr_write_request,
    output logic                    instr_retired,
    output logic [SB_CNT_W-1:0]     sb_count
`ifdef RV32_LSU_MISALIGN_TRAP_EN
    ,
    output logic                    misalign_fault
`endif
);
    localparam int PTR_W = $clog2(SB_DEPTH);

    memory_request_t  sb_mem [SB_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;

    mem_op_t     op;
    logic [31:0] addr_raw, bus_addr;
    logic        is_store, is_load, is_half, is_word, misaligned;
    logic        do_int, go, sb_empty, sb_full, pop, enq, load_issue;

    assign op       = exec_mem_buff.control.mem_op;
    assign addr_raw = exec_mem_buff.data_result[1];
    assign is_store = ~exec_mem_buff.control.is_bubble && (op inside {MEM_SB, MEM_SH, MEM_SW});
    assign is_load  = ~exec_mem_buff.control.is_bubble && (op != MEM_NOP) && !is_store;
    assign is_half  = op inside {MEM_LH, MEM_LHU, MEM_SH};
    assign is_word  = op inside {MEM_LW, MEM_SW};

`ifdef RV32_LSU_MISALIGN_TRAP_EN
    assign misaligned     = (is_store | is_load) &
                            ((is_half & addr_raw[0]) | (is_word & (|addr_raw[1:0])));
    assign bus_addr       = addr_raw;
    assign misalign_fault = resetn & misaligned;
`else
    assign misaligned = 1'b0;
    assign bus_addr   = {addr_raw[31:2], addr_raw[1] & ~is_word, addr_raw[0] & ~(is_half | is_word)};
`endif

    assign do_int     = (mtip & mstatus.mie) | exec_mem_buff.control.is_mret;
    assign go         = ~do_int & ~misaligned;
    assign sb_empty   = (sb_count == '0);
    assign sb_full    = (sb_count == SB_CNT_W'(SB_DEPTH));
    assign pop        = ~sb_empty & request_done;
    assign enq        = is_store & go & (~sb_full | pop);
    assign load_issue = is_load & go & sb_empty;
    // Loads wait behind buffered stores, then hold the pipe until the bus answers.
    assign stall      = (is_store & go & sb_full & ~pop) |
                        (is_load & go & (~sb_empty | ~request_done));

    always_comb begin
        data_request = '{addr: '0, op: MEM_NOP, data: '0};
        if (resetn) begin
            if (!sb_empty)
                data_request = sb_mem[rd_ptr];
            else if (load_issue)
                data_request = '{addr: bus_addr, op: op, data: '0};
        end
    end

    assign interrupt_request = '{from: exec_mem_buff.pc,
                                 is_mret: exec_mem_buff.control.is_mret,
                                 do_interrupt: do_int};
    assign csr_write_request = '{id: exec_mem_buff.instr[31:20],
                                 value: exec_mem_buff.data_result[1],
                                 write: exec_mem_buff.control.csr_wb & ~do_int & ~stall & ~misaligned};
    assign instr_retired = ~(exec_mem_buff.control.is_bubble | stall | do_int | misaligned);

    always_ff @(posedge clk) begin
        if (enq)
            sb_mem[wr_ptr] <= '{addr: bus_addr, op: op, data: exec_mem_buff.data_result[0]};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr              <= '0;
            wr_ptr              <= '0;
            sb_count            <= '0;
            mem_wb_buff.instr   <= RV_NOP;
            mem_wb_buff.pc      <= '0;
            mem_wb_buff.control <= BUBBLE_CONTROL;
            mem_wb_buff.data_result <= '0;
        end else begin
            if (enq)
                wr_ptr <= (wr_ptr == PTR_W'(SB_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(SB_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({enq, pop})
                2'b10:   sb_count <= sb_count + SB_CNT_W'(1);
                2'b01:   sb_count <= sb_count - SB_CNT_W'(1);
                default: sb_count <= sb_count;
            endcase

            if (do_int || misaligned) begin
                mem_wb_buff         <= exec_mem_buff;
                mem_wb_buff.control <= BUBBLE_CONTROL;
            end else if (stall) begin
                // Keep the other fields so the bypass network still sees them.
                mem_wb_buff.control.is_bubble <= 1'b1;
            end else begin
                mem_wb_buff <= exec_mem_buff;
            end
        end
    end
endmodule

// File: tb/tb_rv32_lsu_stage.sv
// Randomized scoreboard bench for rv32_lsu_stage against a queue-based store-buffer model.
module tb_rv32_lsu_stage;
    import rv32_lsu_pkg::*;

    localparam int D = 4;

    logic               clk = 1'b0;
    logic               resetn;
    mstatus_t           mstatus;
    logic               mtip;
    exec_mem_buffer_t   ex;
    mem_wb_buffer_t     mwb;
    logic               stall;
    interrupt_request_t irq;
    memory_request_t    dreq;
    logic               request_done;
    csr_write_request_t csr;
    logic               instr_retired;
    logic [2:0]         sb_count;
`ifdef RV32_LSU_MISALIGN_TRAP_EN
    logic               misalign_fault;
`endif

    rv32_lsu_stage #(.SB_DEPTH(D)) dut (
        .clk(clk), .resetn(resetn), .mstatus(mstatus), .mtip(mtip),
        .exec_mem_buff(ex), .mem_wb_buff(mwb), .stall(stall),
        .interrupt_request(irq), .data_request(dreq), .request_done(request_done),
        .csr_write_request(csr), .instr_retired(instr_retired), .sb_count(sb_count)
`ifdef RV32_LSU_MISALIGN_TRAP_EN
        , .misalign_fault(misalign_fault)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          full;
        bit          stall, retired, csr_w, doi, mis;
        int          cnt;
        mem_op_t     op;
        logic [31:0] addr, data, from, wb_pc;
        bit          wb_bub;
    } status_t;

    status_t         stq[$];
    memory_request_t busq[$];
    logic [31:0]     retq[$];
    memory_request_t mq[$];
    logic [31:0]     m_wb_pc;
    bit              m_wb_bub, m_known;
    int              n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_half_op(mem_op_t o);
        return o == MEM_LH || o == MEM_LHU || o == MEM_SH;
    endfunction
    function automatic bit is_word_op(mem_op_t o);
        return o == MEM_LW || o == MEM_SW;
    endfunction

    function automatic bit misal(mem_op_t o, logic [31:0] a);
`ifdef RV32_LSU_MISALIGN_TRAP_EN
        return (is_half_op(o) && (a % 2) != 0) || (is_word_op(o) && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] norm(mem_op_t o, logic [31:0] a);
`ifdef RV32_LSU_MISALIGN_TRAP_EN
        return a;
`else
        if (is_word_op(o)) return a - (a % 4);
        if (is_half_op(o)) return a - (a % 2);
        return a;
`endif
    endfunction

    function automatic exec_mem_buffer_t mk(mem_op_t o, logic [31:0] pc, logic [31:0] a,
                                            logic [31:0] d, bit bub = 0, bit mret = 0, bit cw = 0);
        exec_mem_buffer_t e;
        e = '0;
        e.instr = {12'h340 + 12'(pc[7:0]), 20'h00073};
        e.pc = pc;
        e.control.is_bubble = bub;
        e.control.is_mret = mret;
        e.control.csr_wb = cw;
        e.control.mem_op = o;
        e.data_result[1] = a;
        e.data_result[0] = d;
        return e;
    endfunction

    // One clock: drive inputs, predict this cycle's outputs, advance the model past the edge.
    task automatic step(input exec_mem_buffer_t e, input bit tip, input bit mie, input bit rd,
                        input bit rst_n, output bit st);
        status_t s;
        bit bub, isst, isld, doi, mis, go, pop, enq;
        int sz;
        mem_op_t o;
        @(posedge clk);
        #1;
        ex = e; mtip = tip; mstatus.mie = mie; request_done = rd; resetn = rst_n;
        s = '{full: 0, stall: 0, retired: 0, csr_w: 0, doi: 0, mis: 0, cnt: mq.size(),
              op: MEM_NOP, addr: 0, data: 0, from: e.pc, wb_pc: m_wb_pc, wb_bub: m_wb_bub};
        st = 0;
        if (!rst_n) begin
            if (m_known) stq.push_back(s);
            mq.delete();
            m_wb_pc = 0; m_wb_bub = 1; m_known = 1;
            return;
        end
        o = e.control.mem_op;
        bub = e.control.is_bubble;
        isst = !bub && (o == MEM_SB || o == MEM_SH || o == MEM_SW);
        isld = !bub && o != MEM_NOP && !isst;
        doi = (tip && mie) || e.control.is_mret;
        mis = (isst || isld) && misal(o, e.data_result[1]);
        go = !doi && !mis;
        sz = mq.size();
        pop = sz > 0 && rd;
        enq = 0;
        if (sz > 0) begin
            s.op = mq[0].op; s.addr = mq[0].addr; s.data = mq[0].data;
        end else if (isld && go) begin
            s.op = o; s.addr = norm(o, e.data_result[1]);
        end
        if (pop) busq.push_back(mq[0]);
        if (isst && go) begin
            if (sz < D || pop) enq = 1;
            else s.stall = 1;
        end
        if (isld && go) begin
            if (sz > 0) s.stall = 1;
            else if (rd) busq.push_back('{addr: norm(o, e.data_result[1]), op: o, data: 0});
            else s.stall = 1;
        end
        s.full = 1;
        s.doi = doi;
        s.mis = mis;
        s.retired = !bub && !s.stall && !doi && !mis;
        s.csr_w = e.control.csr_wb && !doi && !s.stall && !mis;
        if (s.retired) retq.push_back(e.pc);
        stq.push_back(s);
        if (pop) void'(mq.pop_front());
        if (enq) mq.push_back('{addr: norm(o, e.data_result[1]), op: o, data: e.data_result[0]});
        if (doi || mis) begin
            m_wb_pc = e.pc; m_wb_bub = 1;
        end else if (s.stall) begin
            m_wb_bub = 1;
        end else begin
            m_wb_pc = e.pc; m_wb_bub = bub;
        end
        st = s.stall;
    endtask

    always @(negedge clk) begin
        status_t s;
        memory_request_t b;
        logic [31:0] p;
        if (stq.size() > 0) begin
            s = stq.pop_front();
            chk("sb_count", 32'(sb_count), 32'(s.cnt));
            chk("req_op", 32'(dreq.op), 32'(s.op));
            if (s.op != MEM_NOP) begin
                chk("req_addr", dreq.addr, s.addr);
                chk("req_data", dreq.data, s.data);
            end
            chk("wb_pc", mwb.pc, s.wb_pc);
            chk("wb_bubble", 32'(mwb.control.is_bubble), 32'(s.wb_bub));
`ifdef RV32_LSU_MISALIGN_TRAP_EN
            chk("misalign", 32'(misalign_fault), 32'(s.mis));
`endif
            if (s.full) begin
                chk("stall", 32'(stall), 32'(s.stall));
                chk("retired", 32'(instr_retired), 32'(s.retired));
                chk("csr_write", 32'(csr.write), 32'(s.csr_w));
                chk("do_interrupt", 32'(irq.do_interrupt), 32'(s.doi));
                chk("irq_from", irq.from, s.from);
            end
        end
        if (resetn === 1'b1 && request_done === 1'b1 && dreq.op != MEM_NOP) begin
            if (busq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL bus_txn: unexpected op %0d addr %h, expected none", dreq.op, dreq.addr);
            end else begin
                b = busq.pop_front();
                chk("bus_txn_op", 32'(dreq.op), 32'(b.op));
                chk("bus_txn_addr", dreq.addr, b.addr);
                chk("bus_txn_data", dreq.data, b.data);
            end
        end
        if (resetn === 1'b1 && instr_retired === 1'b1) begin
            if (retq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL retire: unexpected retire pc %h, expected none", ex.pc);
            end else begin
                p = retq.pop_front();
                chk("retire_pc", ex.pc, p);
            end
        end
    end

    initial begin
        exec_mem_buffer_t bubble, cur;
        mem_op_t stops[3];
        mem_op_t ldops[5];
        bit st;
        int r;
        logic [31:0] pc;
        stops = '{MEM_SB, MEM_SH, MEM_SW};
        ldops = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
        bubble = mk(MEM_NOP, 0, 0, 0, 1);
        resetn = 0; mtip = 0; mstatus = '0; request_done = 0; ex = bubble;
        m_known = 0; m_wb_pc = 0; m_wb_bub = 1;
        step(bubble, 0, 0, 0, 0, st);
        step(bubble, 0, 0, 0, 0, st);

        // Five back-to-back stores into an idle bus; the fifth finds it full.
        for (int i = 0; i < 5; i++)
            step(mk(MEM_SW, 32'h100 + 4 * i, 32'h2000 + 4 * i, 32'hA0 + i), 0, 0, 0, 1, st);
        // Full buffer, store with a same-cycle pop: accepted, write pointer wraps.
        step(mk(MEM_SW, 32'h110, 32'h2010, 32'hA4), 0, 0, 1, 1, st);
        for (int i = 0; i < 5; i++) step(bubble, 0, 0, 1, 1, st);

        // Load behind two buffered stores.
        step(mk(MEM_SH, 32'h200, 32'h3002, 32'hB0), 0, 0, 0, 1, st);
        step(mk(MEM_SB, 32'h204, 32'h3005, 32'hB1), 0, 0, 0, 1, st);
        step(mk(MEM_LW, 32'h208, 32'h3008, 0), 0, 0, 0, 1, st);
        step(mk(MEM_LW, 32'h208, 32'h3008, 0), 0, 0, 1, 1, st);
        step(mk(MEM_LW, 32'h208, 32'h3008, 0), 0, 0, 1, 1, st);
        step(mk(MEM_LW, 32'h208, 32'h3008, 0), 0, 0, 0, 1, st);
        step(mk(MEM_LW, 32'h208, 32'h3008, 0), 0, 0, 1, 1, st);

        // Timer interrupt while a store is buffered, then an mret and a CSR write.
        step(mk(MEM_SW, 32'h300, 32'h4000, 32'hC0), 0, 1, 0, 1, st);
        step(mk(MEM_SW, 32'h304, 32'h4004, 32'hC1), 1, 1, 0, 1, st);
        step(bubble, 0, 0, 1, 1, st);
        step(mk(MEM_NOP, 32'h308, 0, 0, 0, 1, 1), 0, 0, 0, 1, st);
        step(mk(MEM_NOP, 32'h30C, 32'h55, 0, 0, 0, 1), 0, 0, 0, 1, st);

        // Misaligned word load (traps when the trap build is selected).
        step(mk(MEM_LW, 32'h400, 32'h1002, 0), 0, 0, 1, 1, st);

        // Reset with three stores buffered.
        for (int i = 0; i < 3; i++)
            step(mk(MEM_SB, 32'h500 + 4 * i, 32'h5000 + i, 32'hD0 + i), 0, 0, 0, 1, st);
        step(bubble, 0, 0, 0, 0, st);
        step(bubble, 0, 0, 1, 1, st);

        st = 0; pc = 32'h1000; cur = bubble;
        for (int it = 0; it < 3000; it++) begin
            if ($urandom % 500 == 0) begin
                step(bubble, 0, 0, 0, 0, st);
                st = 0;
                continue;
            end
            if (!st) begin
                r = $urandom % 10;
                pc += 4;
                if (r < 2)      cur = mk(MEM_NOP, pc, 0, 0, 1);
                else if (r < 6) cur = mk(stops[$urandom % 3], pc, $urandom & 32'hFFFF, $urandom);
                else if (r < 8) cur = mk(ldops[$urandom % 5], pc, $urandom & 32'hFFFF, $urandom);
                else            cur = mk(MEM_NOP, pc, $urandom, 0, 0, ($urandom % 8) == 0, ($urandom % 2) == 1);
            end
            step(cur, ($urandom % 20) == 0, $urandom % 2, ($urandom % 3) != 0, 1, st);
        end

        for (int i = 0; i < 8; i++) step(bubble, 0, 0, 1, 1, st);
        @(negedge clk);
        @(negedge clk);
        chk("bus_queue_drained", 32'(busq.size()), 0);
        chk("retire_queue_drained", 32'(retq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
